// File: rtl/conv_deserializer.sv
// DDR receive deserializer: captures one bit per clock phase, hunts for a sync word
// to find the word boundary, and delivers aligned words through a valid/ready register.
module conv_deserializer #(
  parameter int unsigned       WORD_W    = 8,
  parameter logic [WORD_W-1:0] SYNC_WORD = 8'hA5,
  parameter int unsigned       LOCK_CNT  = 2,
  parameter bit                DROP_SYNC = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_serial_in,
  input  logic              i_align_req,
  output logic [WORD_W-1:0] o_par_out,
  output logic              o_par_valid,
  input  logic              i_par_ready,
  output logic              o_locked,
  output logic              o_overflow
);

  localparam int unsigned    HALF   = WORD_W / 2;
  localparam int unsigned    CW     = $clog2(HALF + 1);
  localparam int unsigned    MW     = $clog2(LOCK_CNT + 1);
  localparam logic [CW-1:0]  HALF_C = CW'(HALF);
  localparam logic [CW-1:0]  ONE_C  = CW'(1);
  localparam logic [MW:0]    LOCK_C = (MW + 1)'(LOCK_CNT);

  typedef enum logic [1:0] {
    S_HUNT    = 2'd0,
    S_CONFIRM = 2'd1,
    S_LOCKED  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_neg_bit;
  logic [WORD_W-1:0]   r_shreg;
  logic [CW-1:0]       r_fill_cnt;
  logic [CW-1:0]       r_pair_cnt;
  logic [MW-1:0]       r_match_cnt;
  logic [WORD_W-1:0]   r_par_out;
  logic                r_par_valid;
  logic                r_locked;
  logic                r_overflow;

  logic                w_fill_sat;
  logic                w_boundary;
  logic                w_sync_hit;
  logic [MW:0]         w_match_inc;
  logic                w_lock_reached;
  logic                w_fill_clr;
  logic                w_match_clr;
  logic                w_match_en;
  logic                w_pair_rst;
  logic                w_offer;
  logic                w_load;

  assign w_fill_sat     = (r_fill_cnt == HALF_C);
  assign w_boundary     = (r_pair_cnt == HALF_C);
  assign w_sync_hit     = (r_shreg == SYNC_WORD);
  assign w_match_inc    = {1'b0, r_match_cnt} + (MW + 1)'(1);
  assign w_lock_reached = (w_match_inc == LOCK_C);
  assign w_load         = w_offer && (!r_par_valid || i_par_ready);

  // High-phase bit is sampled on the falling edge; it is the earlier bit of each pair.
  always_ff @(negedge i_clk) begin
    if (i_reset) begin
      r_neg_bit <= 1'b0;
    end else begin
      r_neg_bit <= i_serial_in;
    end
  end

  // Alignment FSM: ALIGN_REQ takes priority over every lock and load decision.
  always_comb begin
    w_state_nxt = r_state;
    w_fill_clr  = 1'b0;
    w_match_clr = 1'b0;
    w_match_en  = 1'b0;
    w_pair_rst  = 1'b0;
    w_offer     = 1'b0;
    if (i_align_req) begin
      w_state_nxt = S_HUNT;
      w_fill_clr  = 1'b1;
      w_match_clr = 1'b1;
    end else begin
      case (r_state)
        S_HUNT: begin
          if (w_fill_sat && w_sync_hit) begin
            w_state_nxt = S_CONFIRM;
            w_pair_rst  = 1'b1;
            w_match_clr = 1'b1;
          end else begin
            w_state_nxt = S_HUNT;
          end
        end
        S_CONFIRM: begin
          if (w_boundary && w_sync_hit) begin
            w_match_en  = 1'b1;
            w_state_nxt = w_lock_reached ? S_LOCKED : S_CONFIRM;
          end else if (w_boundary) begin
            w_state_nxt = S_HUNT;
            w_fill_clr  = 1'b1;
          end else begin
            w_state_nxt = S_CONFIRM;
          end
        end
        S_LOCKED: begin
          w_state_nxt = S_LOCKED;
          w_offer     = w_boundary && !(DROP_SYNC && w_sync_hit);
        end
        default: begin
          w_state_nxt = S_HUNT;
          w_fill_clr  = 1'b1;
          w_match_clr = 1'b1;
        end
      endcase
    end
  end

  // Shift register, pair/fill/match counters and state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_HUNT;
      r_locked    <= 1'b0;
      r_shreg     <= '0;
      r_fill_cnt  <= '0;
      r_pair_cnt  <= ONE_C;
      r_match_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_locked <= (w_state_nxt == S_LOCKED);
      r_shreg  <= {r_shreg[WORD_W-3:0], r_neg_bit, i_serial_in};
      if (w_fill_clr) begin
        r_fill_cnt <= '0;
      end else if (!w_fill_sat) begin
        r_fill_cnt <= r_fill_cnt + ONE_C;
      end
      if (w_pair_rst || w_boundary) begin
        r_pair_cnt <= ONE_C;
      end else begin
        r_pair_cnt <= r_pair_cnt + ONE_C;
      end
      if (w_match_clr) begin
        r_match_cnt <= '0;
      end else if (w_match_en) begin
        r_match_cnt <= w_match_inc[MW-1:0];
      end
    end
  end

  // Output register; a word offered while a stalled word is pending is dropped.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_par_out   <= '0;
      r_par_valid <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_load) begin
        r_par_out   <= r_shreg;
        r_par_valid <= 1'b1;
      end else if (i_par_ready) begin
        r_par_valid <= 1'b0;
      end
      if (w_offer && !w_load) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign o_par_out   = r_par_out;
  assign o_par_valid = r_par_valid;
  assign o_locked    = r_locked;
  assign o_overflow  = r_overflow;

endmodule

// File: doc/conv_deserializer.md
Name: conv_deserializer

Overview:
Receive-side counterpart of the DDR 2:1 serializer. Samples SERIAL_IN on both edges of CLK and assembles bit pairs into WORD_W-bit words. Finds the word boundary by hunting for a sync pattern. Delivers aligned words through a valid/ready output register with overflow detection.

Parameters:
WORD_W, 8, output word width; must be even and >= 4
SYNC_WORD, 8'hA5, alignment pattern, WORD_W bits wide
LOCK_CNT, 2, consecutive boundary-aligned SYNC_WORD matches needed after first hit to declare lock (>= 1)
DROP_SYNC, 1, 1 = words equal to SYNC_WORD are not delivered while LOCKED

Ports:
CLK  in  1  single clock; posedge logic plus one negedge capture flop
RESET  in  1  synchronous, active-high reset, sampled on posedge CLK
SERIAL_IN  in  1  DDR serial data; one bit during CLK high, one during CLK low
ALIGN_REQ  in  1  one-cycle pulse; forces re-hunt
PAR_OUT  out  WORD_W  aligned word; earliest-received bit in MSB
PAR_VALID  out  1  PAR_OUT holds an undelivered word
PAR_READY  in  1  consumer accepts the word when PAR_VALID && PAR_READY at posedge
LOCKED  out  1  high in LOCKED state
OVERFLOW  out  1  sticky; a completed word was lost to backpressure

Behaviour:
- Capture: NEG_BIT samples SERIAL_IN on negedge CLK (the high-phase bit). At each posedge, shreg <= {shreg[WORD_W-3:0], NEG_BIT, SERIAL_IN}. High-phase bit is earlier in time; low-phase bit is later.
- Alignment granularity is one pair, giving WORD_W/2 candidate phases. Odd-bit slip is not supported.
- fill_cnt counts pairs since reset or re-hunt and saturates at WORD_W/2. Compares are allowed only when saturated.
- pair_cnt ranges 1..WORD_W/2. A boundary edge is a posedge with pair_cnt == WORD_W/2. On a boundary edge, pair_cnt <= 1; otherwise it increments.
- All compares and loads use registered shreg. Latency from the posedge capturing a word's last pair to PAR_VALID high is 1 cycle.
- FSM states: HUNT, CONFIRM, LOCKED.
  - HUNT: every posedge with fill saturated and shreg == SYNC_WORD -> CONFIRM, pair_cnt <= 1, match_cnt <= 0.
  - CONFIRM: on a boundary edge, a match increments match_cnt. If match_cnt+1 == LOCK_CNT -> LOCKED. A mismatch -> HUNT and clears fill_cnt.
  - LOCKED: on a boundary edge, shreg is offered to the output unless DROP_SYNC && shreg == SYNC_WORD. Loss of alignment is never detected autonomously.
  - ALIGN_REQ in any state -> HUNT, clears fill_cnt and match_cnt. ALIGN_REQ overrides a simultaneous lock or load decision.
- Output register:
  - Load when an offer occurs and (!PAR_VALID || PAR_READY). PAR_VALID <= 1.
  - Offer with PAR_VALID && !PAR_READY: word discarded, OVERFLOW <= 1, PAR_OUT unchanged.
  - PAR_READY with no load: PAR_VALID <= 0.
  - Simultaneous accept and load: back-to-back, PAR_VALID stays 1.
  - PAR_VALID and PAR_OUT hold while stalled. Leaving LOCKED does not flush a pending word.
- Reset values: shreg = 0, fill_cnt = 0, pair_cnt = 1, match_cnt = 0, state = HUNT, PAR_OUT = 0, PAR_VALID = 0, LOCKED = 0, OVERFLOW = 0.
  - NEG_BIT is cleared at negedge while RESET is high.
  - RESET mid-word or mid-lock abandons all partial state. OVERFLOW clears only on RESET.
- Throughput: one word per WORD_W/2 cycles. PAR_READY may be low for up to WORD_W/2-1 cycles per word without loss.

Test Plan:
- Reset: hold RESET 3 cycles with SERIAL_IN toggling -> all outputs 0, LOCKED=0, no PAR_VALID for 4 cycles after release with idle input.
- Lock (WORD_W=8, LOCK_CNT=2): serializer sends 3 garbage pairs, then A5 A5 A5 3C C3 -> LOCKED rises on the third A5 boundary. PAR_OUT = 3C then C3, each PAR_VALID one cycle after its last pair, PAR_READY=1, OVERFLOW=0.
- Confirm failure: A5 then 5A at the next boundary -> returns to HUNT, LOCKED stays 0. A later A5 A5 A5 locks.
- Backpressure: locked, stream 11 22 33 with PAR_READY=0 -> PAR_OUT stays 11, OVERFLOW=1 at the 22 boundary. Raise PAR_READY -> 11 accepted, then 33 delivered.
- Re-align: locked, pulse ALIGN_REQ coincident with a boundary -> no load that cycle, LOCKED=0 next cycle. Stream shifted by one pair relocks on A5 A5 A5 with correct data after.
- Reset mid-operation: RESET for 1 cycle while locked with PAR_VALID=1 -> PAR_VALID=0, OVERFLOW=0, LOCKED=0, full re-hunt required.
